// File: rtl/lzd_pkg.sv
// Shared constants and the half-merge rule for the leading-zero detector tree.
package lzd_pkg;

  localparam int unsigned W_MIN = 8;
  localparam int unsigned W_MAX = 64;

  // Width of a count that can hold 0..w inclusive.
  function automatic int unsigned lzc_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  // Merge two half-width counts: a fully zero upper half adds its whole width.
  function automatic logic [7:0] merge_lzc(input logic       az_hi,
                                           input logic [7:0] lzc_hi,
                                           input logic [7:0] lzc_lo,
                                           input logic [7:0] half);
    return az_hi ? (half + lzc_lo) : lzc_hi;
  endfunction

endpackage

// File: rtl/lzd_nbit.sv
// Combinational recursive leading-zero counter over an N-bit vector (N a power of two).
module lzd_nbit
  import lzd_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]              data,
  output logic [lzc_width(N)-1:0]   count,
  output logic                      all_zero
);

  localparam int unsigned CW = lzc_width(N);

  if (N == 1) begin : g_leaf
    assign count    = ~data;
    assign all_zero = ~data[0];
  end else begin : g_split
    localparam int unsigned H  = N / 2;
    localparam int unsigned HW = lzc_width(H);

    logic [HW-1:0] cnt_hi;
    logic [HW-1:0] cnt_lo;
    logic          az_hi;
    logic          az_lo;

    lzd_nbit #(.N(H)) u_hi (
      .data     (data[N-1:H]),
      .count    (cnt_hi),
      .all_zero (az_hi)
    );

    lzd_nbit #(.N(H)) u_lo (
      .data     (data[H-1:0]),
      .count    (cnt_lo),
      .all_zero (az_lo)
    );

    assign all_zero = az_hi & az_lo;
    assign count    = CW'(merge_lzc(az_hi, 8'(cnt_hi), 8'(cnt_lo), 8'(H)));
  end

endmodule

// File: rtl/lzd_norm_pipe.sv
// Two-stage leading-zero count / normalize pipeline with valid-ready flow control.
// Define LZD_NORM_SHIFT_EN to build the normalizing shifter and the out_norm port.
module lzd_norm_pipe
  import lzd_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [lzc_width(W)-1:0]  out_lzc,
  output logic                     out_all_zero
`ifdef LZD_NORM_SHIFT_EN
  ,
  output logic [W-1:0]             out_norm
`endif
);

  localparam int unsigned H      = W / 2;
  localparam int unsigned LZC_W  = lzc_width(W);
  localparam int unsigned HLZC_W = lzc_width(H);

  logic [HLZC_W-1:0] lzc_hi_c;
  logic [HLZC_W-1:0] lzc_lo_c;
  logic              az_hi_c;
  logic              az_lo_c;

  lzd_nbit #(.N(H)) u_lzd_hi (
    .data     (in_data[W-1:H]),
    .count    (lzc_hi_c),
    .all_zero (az_hi_c)
  );

  lzd_nbit #(.N(H)) u_lzd_lo (
    .data     (in_data[H-1:0]),
    .count    (lzc_lo_c),
    .all_zero (az_lo_c)
  );

  logic              s1_valid;
  logic [HLZC_W-1:0] s1_lzc_hi;
  logic [HLZC_W-1:0] s1_lzc_lo;
  logic              s1_az_hi;
  logic              s1_az_lo;

  logic              s2_valid;
  logic [LZC_W-1:0]  s2_lzc;
  logic              s2_az;

  logic              s2_adv;
  logic              s1_adv;
  logic [LZC_W-1:0]  lzc_m;
  logic              az_m;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  // Gated by rst so upstream never sees a transfer the reset would discard.
  assign in_ready = !rst && s1_adv;

  assign lzc_m = LZC_W'(merge_lzc(s1_az_hi, 8'(s1_lzc_hi), 8'(s1_lzc_lo), 8'(H)));
  assign az_m  = s1_az_hi & s1_az_lo;

`ifdef LZD_NORM_SHIFT_EN
  logic [W-1:0] s1_data;
  logic [W-1:0] s2_norm;
  logic [W-1:0] norm_m;

  // A shift by W (all-zero operand) yields zero, which is the wanted result.
  assign norm_m   = s1_data << lzc_m;
  assign out_norm = s2_norm;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data <= '0;
      s2_norm <= '0;
    end else begin
      if (s1_adv && in_valid) s1_data <= in_data;
      if (s2_adv && s1_valid) s2_norm <= norm_m;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_lzc_hi <= '0;
      s1_lzc_lo <= '0;
      s1_az_hi  <= 1'b0;
      s1_az_lo  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_lzc    <= '0;
      s2_az     <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_lzc_hi <= lzc_hi_c;
          s1_lzc_lo <= lzc_lo_c;
          s1_az_hi  <= az_hi_c;
          s1_az_lo  <= az_lo_c;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_lzc <= lzc_m;
          s2_az  <= az_m;
        end
      end
    end
  end

  assign out_valid    = s2_valid;
  assign out_lzc      = s2_lzc;
  assign out_all_zero = s2_az;

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Scoreboard bench for lzd_norm_pipe (W=32); honours LZD_NORM_SHIFT_EN when defined.
module tb_lzd_norm_pipe;

  localparam int W  = 32;
  localparam int LW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_lzc;
  logic          out_all_zero;
`ifdef LZD_NORM_SHIFT_EN
  logic [W-1:0]  out_norm;
`endif

  lzd_norm_pipe #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lzc      (out_lzc),
    .out_all_zero (out_all_zero)
`ifdef LZD_NORM_SHIFT_EN
    ,
    .out_norm     (out_norm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           lzc;
    bit           az;
    logic [W-1:0] norm;
    int           cyc;
    int           stalls;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   stalls = 0;
  bit   done = 0;

  always @(posedge clk) cyc++;

  // Reference: count zeros from the MSB down, then shift by that count.
  function automatic exp_t model(input logic [W-1:0] d);
    exp_t e;
    int   z = 0;
    for (int i = W - 1; i >= 0 && d[i] == 1'b0; i--) z++;
    e.lzc    = z;
    e.az     = (d == '0);
    e.norm   = (z >= W) ? '0 : (d << z);
    e.cyc    = 0;
    e.stalls = 0;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: pushes on accepted input, pops and compares on each output transfer.
  bit           hold_prev = 0;
  logic [LW-1:0] p_lzc;
  logic          p_az;
  logic [W-1:0]  p_norm;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_lzc", out_lzc, p_lzc);
        check("hold_az", out_all_zero, p_az);
`ifdef LZD_NORM_SHIFT_EN
        check("hold_norm", out_norm, p_norm);
`endif
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got lzc %0d, expected no result", out_lzc);
        end else begin
          e = q.pop_front();
          check("lzc", out_lzc, e.lzc);
          check("all_zero", out_all_zero, e.az);
`ifdef LZD_NORM_SHIFT_EN
          check("norm", out_norm, e.norm);
`endif
          if (e.stalls == stalls) check("latency", cyc - e.cyc, 2);
        end
      end
      if (out_valid && !out_ready) stalls++;
      if (in_valid && in_ready) begin
        e = model(in_data);
        e.cyc    = cyc;
        e.stalls = stalls;
        q.push_back(e);
      end
      hold_prev = out_valid && !out_ready;
      p_lzc  = out_lzc;
      p_az   = out_all_zero;
`ifdef LZD_NORM_SHIFT_EN
      p_norm = out_norm;
`else
      p_norm = '0;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present d until accepted; leaves in_valid high so bursts have no bubbles.
  task automatic send(input logic [W-1:0] d, input bit chk_ready);
    bit got = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (chk_ready) check("in_ready_b2b", in_ready, 1);
      got = in_ready;
      tick();
    end
    if (!got) begin
      n_total++;
      $display("FAIL accept_timeout: got in_ready 0 for 200 cycles, expected 1");
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    int unsigned  k = $urandom_range(0, 33);
    logic [W-1:0] r = $urandom();
    return (k >= W) ? '0 : (r >> k);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_lzc", out_lzc, 0);
    check("rst_out_az", out_all_zero, 0);
    check("rst_in_ready", in_ready, 0);
`ifdef LZD_NORM_SHIFT_EN
    check("rst_out_norm", out_norm, 0);
`endif
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    tick();

    send(32'h0000_0000, 0); in_valid = 1'b0; wait_empty();
    send(32'h0001_8000, 0); in_valid = 1'b0; wait_empty();

    send(32'h8000_0000, 1);
    send(32'h0000_0001, 1);
    send(32'h0F00_0000, 1);
    in_valid = 1'b0; wait_empty();

    out_ready = 1'b0;
    send(32'h0000_00F0, 0);
    send(32'h0200_0000, 0);
    in_valid = 1'b1; in_data = 32'h0000_3000;
    repeat (5) begin
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    send(32'h0000_3000, 0);
    in_valid = 1'b0; wait_empty();

    out_ready = 1'b0;
    send(32'h0000_0010, 0);
    send(32'h0040_0000, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (6) begin
      tick();
      @(negedge clk);
      check("flush_no_output", out_valid, 0);
    end
    tick();

    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick();
          end
          send(rand_op(), 0);
        end
        in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
